// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between the issue stage, the RV32M unit and the register file.
interface muldiv_unit_if;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (
    output start, flush, op, rs1_data, rs2_data, rd_addr,
    input  busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, flush, op, rs1_data, rs2_data, rd_addr,
    output busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 radix-2 iterations on operand magnitudes,
// sign correction and result select in a final cycle, then a one-cycle write request.
module muldiv_unit (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        accept_s, finish_s;
  logic [4:0]  cnt_r;
  logic [2:0]  op_r;
  logic [32:0] acc_hi_r;
  logic [31:0] acc_lo_r;
  logic [31:0] opnd_r;
  logic        neg_a_r, neg_b_r, div_zero_r;
  logic        busy_r, done_r, wr_en_r;
  logic [4:0]  wr_addr_r;
  logic [31:0] wr_data_r;

  logic        sgn_a_s, sgn_b_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [32:0] sum_s, rem_sh_s;
  logic [33:0] diff_s;
  logic        ge_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s, result_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Operand signedness decode on the issuing op.
  always_comb begin
    sgn_a_s = 1'b0;
    sgn_b_s = 1'b0;
    case (bus.op)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        sgn_a_s = bus.rs1_data[31];
        sgn_b_s = bus.rs2_data[31];
      end
      3'd2: begin
        sgn_a_s = bus.rs1_data[31];
        sgn_b_s = 1'b0;
      end
      default: begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
      end
    endcase
    mag_a_s = sgn_a_s ? neg32(bus.rs1_data) : bus.rs1_data;
    mag_b_s = sgn_b_s ? neg32(bus.rs2_data) : bus.rs2_data;
  end

  // Next-state logic; flush always wins over start and over completion.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          state_s  = ST_RUN;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_s = ST_IDLE;
        end else if (cnt_r == 5'd31) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
        if (bus.flush) begin
          finish_s = 1'b0;
        end else begin
          finish_s = 1'b1;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // One iteration of shift-add (multiply) and restoring shift-subtract (divide).
  always_comb begin
    sum_s    = acc_hi_r + (acc_lo_r[0] ? {1'b0, opnd_r} : 33'd0);
    rem_sh_s = {acc_hi_r[31:0], acc_lo_r[31]};
    diff_s   = {1'b0, rem_sh_s} - {2'b00, opnd_r};
    ge_s     = ~diff_s[33];
  end

  // Sign correction and result select; a zero divisor keeps the all-ones quotient.
  always_comb begin
    prod_s = {acc_hi_r[31:0], acc_lo_r};
    if (neg_a_r ^ neg_b_r) begin
      prod_s = ~prod_s + 64'd1;
    end else begin
      prod_s = {acc_hi_r[31:0], acc_lo_r};
    end
    quot_s = ((neg_a_r ^ neg_b_r) && !div_zero_r) ? neg32(acc_lo_r) : acc_lo_r;
    rem_s  = neg_a_r ? neg32(acc_hi_r[31:0]) : acc_hi_r[31:0];
    case (op_r)
      3'd0:             result_s = prod_s[31:0];
      3'd1, 3'd2, 3'd3: result_s = prod_s[63:32];
      3'd4, 3'd5:       result_s = quot_s;
      default:          result_s = rem_s;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 5'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 5'd0;
      wr_data_r <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= accept_s ? 5'd0 : ((state_r == ST_RUN) ? cnt_r + 5'd1 : cnt_r);
      busy_r  <= (state_s == ST_RUN) || (state_s == ST_FINISH) || finish_s;
      done_r  <= finish_s;
      wr_en_r <= finish_s && (wr_addr_r != 5'd0);
      if (accept_s) begin
        wr_addr_r <= bus.rd_addr;
      end
      if (finish_s) begin
        wr_data_r <= result_s;
      end
    end
  end

  // Datapath: load magnitudes at acceptance, iterate while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= 3'd0;
      acc_hi_r   <= 33'd0;
      acc_lo_r   <= 32'd0;
      opnd_r     <= 32'd0;
      neg_a_r    <= 1'b0;
      neg_b_r    <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (accept_s) begin
      op_r       <= bus.op;
      acc_hi_r   <= 33'd0;
      acc_lo_r   <= bus.op[2] ? mag_a_s : mag_b_s;
      opnd_r     <= bus.op[2] ? mag_b_s : mag_a_s;
      neg_a_r    <= sgn_a_s;
      neg_b_r    <= sgn_b_s;
      div_zero_r <= (bus.rs2_data == 32'd0);
    end else if (state_r == ST_RUN) begin
      if (op_r[2]) begin
        acc_hi_r <= ge_s ? diff_s[32:0] : rem_sh_s;
        acc_lo_r <= {acc_lo_r[30:0], ge_s};
      end else begin
        acc_hi_r <= {1'b0, sum_s[32:1]};
        acc_lo_r <= {sum_s[0], acc_lo_r[31:1]};
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.wr_en   = wr_en_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_data = wr_data_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;

  muldiv_unit_if bus();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done)  done_cnt++;
    if (bus.wr_en) wr_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Independent reference built from the simulator's own arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu, p;
    logic [63:0]        up;
    logic signed [31:0] a32, b32, r32;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sbu = {32'd0, b};
    a32 = a;
    b32 = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * sbu; return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r32 = a32 / b32; return r32;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r32 = a32 % b32; return r32;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_addr = rd;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input bit noise);
    int cyc = 0;
    accept(op, a, b, rd);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (noise && cyc >= 3 && cyc <= 6) begin
        bus.start = 1'b1; bus.op = ~op; bus.rs1_data = $urandom;
        bus.rs2_data = $urandom; bus.rd_addr = 5'd9;
      end else begin
        bus.start = 1'b0;
      end
    end
    check_val({tag, "_lat"}, 32'(cyc), 32'd33);
    check_val({tag, "_data"}, bus.wr_data, exp);
    check_val({tag, "_wren"}, 32'(bus.wr_en), 32'(rd != 5'd0));
    check_val({tag, "_addr"}, 32'(bus.wr_addr), 32'(rd));
    @(posedge clk); #1;
    check_val({tag, "_done_off"}, 32'(bus.done), 32'd0);
    check_val({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int          d0, w0, nz;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0;
    bus.rs1_data = 32'd0; bus.rs2_data = 32'd0; bus.rd_addr = 5'd0;
    #12;
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_wren", 32'(bus.wr_en), 32'd0);
    check_val("rst_addr", 32'(bus.wr_addr), 32'd0);
    check_val("rst_data", bus.wr_data, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mul",    3'd0, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFE, 1'b0);
    run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'h0000_0001, 1'b0);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 1'b0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0);
    run_op("divu",   3'd5, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h7FFF_FFFC, 1'b0);
    run_op("remu",   3'd7, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h0000_0001, 1'b0);
    run_op("divu0",  3'd5, 32'd123, 32'd0, 5'd7, 32'hFFFF_FFFF, 1'b0);
    run_op("remu0",  3'd7, 32'd123, 32'd0, 5'd7, 32'd123, 1'b0);
    run_op("div0n",  3'd4, 32'hFFFF_FFF9, 32'd0, 5'd7, 32'hFFFF_FFFF, 1'b0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1'b0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1'b0);
    run_op("noise",  3'd0, 32'd3, 32'd4, 5'd7, 32'd12, 1'b1);
    run_op("rd0",    3'd0, 32'd6, 32'd7, 5'd0, 32'd42, 1'b0);

    // Reset in the middle of a divide.
    d0 = done_cnt; w0 = wr_cnt;
    accept(3'd4, 32'd1000, 32'd7, 5'd3);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("mrst_busy", 32'(bus.busy), 32'd0);
    check_val("mrst_done", 32'(bus.done), 32'd0);
    check_val("mrst_wren", 32'(bus.wr_en), 32'd0);
    check_val("mrst_data", bus.wr_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_val("mrst_nowr", 32'(wr_cnt - w0), 32'd0);
    check_val("mrst_nodone", 32'(done_cnt - d0), 32'd0);
    run_op("after_rst", 3'd4, 32'd1000, 32'd7, 5'd3, 32'd142, 1'b0);

    // Flush during the run.
    d0 = done_cnt;
    accept(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4);
    repeat (20) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_val("flush_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check_val("flush_nodone", 32'(done_cnt - d0), 32'd0);

    // Flush together with start while idle.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.rd_addr = 5'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check_val("fs_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check_val("fs_nodone", 32'(done_cnt - d0), 32'd0);

    // Randomized back-to-back issue every 34 cycles.
    w0 = wr_cnt; nz = 0;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick($urandom_range(0, 6));
      b  = pick($urandom_range(0, 6));
      rd = 5'($urandom_range(0, 31));
      if (rd != 5'd0) nz++;
      accept(op, a, b, rd);
      repeat (32) @(posedge clk);
      #1;
      check_val("rnd_early", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      check_val("rnd_done", 32'(bus.done), 32'd1);
      check_val("rnd_data", bus.wr_data, ref_md(op, a, b));
      check_val("rnd_addr", 32'(bus.wr_addr), 32'(rd));
    end
    @(posedge clk); #1;
    check_val("rnd_idle", 32'(bus.busy), 32'd0);
    check_val("rnd_wrcnt", 32'(wr_cnt - w0), 32'(nz));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
